// File: rtl/simple.sv
// -----------------------------------------------------------------------------
// simple -- binary-to-thermometer encoder with a registered shadow stage.
//
// result is a purely combinational thermometer code of a: the low a bits are
// set. A clocked stage keeps a registered copy of the code and the level, plus
// one-cycle strobes that flag a level change and its direction.
//
// Ports
//   clk       in   1      rising-edge system clock
//   rst_n     in   1      asynchronous, active-low reset
//   a         in   IN_W   unsigned level code, 0..2**IN_W-1
//   result    out  OUT_W  combinational thermometer code of a
//   result_q  out  OUT_W  registered copy of result
//   level_q   out  IN_W   registered copy of a
//   changed   out  1      one-cycle pulse: a != previous level_q
//   up        out  1      one-cycle pulse: a >  previous level_q
//   down      out  1      one-cycle pulse: a <  previous level_q
// -----------------------------------------------------------------------------
module simple #(
  parameter int unsigned IN_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         a,
  output logic [(2**IN_W)-2:0]    result,
  output logic [(2**IN_W)-2:0]    result_q,
  output logic [IN_W-1:0]         level_q,
  output logic                    changed,
  output logic                    up,
  output logic                    down
);

  localparam int unsigned OUT_W = (2**IN_W) - 1;

  logic [OUT_W-1:0] result_d;
  logic [IN_W-1:0]  level_d;
  logic             changed_d, changed_q;
  logic             up_d,      up_q;
  logic             down_d,    down_q;

  // Thermometer: bit k is set whenever k lies below the level code.
  always_comb begin
    result = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      result[k] = (k < 32'(a));
    end
  end

  // Direction is taken against the level held before this edge, so a jump of
  // any size produces a single strobe and a steady level produces none.
  always_comb begin
    result_d  = result;
    level_d   = a;
    up_d      = (a > level_q);
    down_d    = (a < level_q);
    changed_d = up_d | down_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      level_q   <= '0;
      changed_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      result_q  <= result_d;
      level_q   <= level_d;
      changed_q <= changed_d;
      up_q      <= up_d;
      down_q    <= down_d;
    end
  end

  assign changed = changed_q;
  assign up      = up_q;
  assign down    = down_q;

endmodule

// File: tb/tb_simple.sv
module tb_simple;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [2:0] a;
  logic [6:0] result;
  logic [6:0] result_q;
  logic [2:0] level_q;
  logic       changed;
  logic       up;
  logic       down;

  simple #(.IN_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .result   (result),
    .result_q (result_q),
    .level_q  (level_q),
    .changed  (changed),
    .up       (up),
    .down     (down)
  );

  typedef struct {
    logic [6:0] rq;
    logic [2:0] lq;
    logic       ch;
    logic       up;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_level = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int therm(input int v);
    return (1 << v) - 1;
  endfunction

  // Expected response of the next rising edge, given the level sampled there.
  task automatic push_edge(input int v);
    exp_t e;
    e.lq = 3'(v);
    e.rq = 7'(therm(v));
    e.ch = (v != model_level);
    e.up = (v > model_level);
    e.dn = (v < model_level);
    exp_q.push_back(e);
    model_level = v;
  endtask

  task automatic drive(input int v);
    @(negedge clk);
    a = 3'(v);
    push_edge(v);
    #1;
    chk("result_comb", int'(result), therm(v));
  endtask

  // Monitor: every edge out of reset must have a queued expectation.
  always @(posedge clk) begin
    if (rst_n) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_q", int'(result_q), int'(e.rq));
        chk("level_q",  int'(level_q),  int'(e.lq));
        chk("changed",  int'(changed),  int'(e.ch));
        chk("up",       int'(up),       int'(e.up));
        chk("down",     int'(down),     int'(e.dn));
        chk("chg_is_or", int'(changed), int'(up | down));
        chk("up_and_dn", int'(up & down), 0);
      end
    end
  end

  initial begin
    clk_en = 1'b0;
    rst_n  = 1'b0;
    a      = '0;

    // Combinational sweep with the clock idle.
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      #10;
      chk("comb_sweep", int'(result), therm(i));
    end

    // Reset held with clock running.
    a = 3'd5;
    clk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_result_q", int'(result_q), 0);
      chk("rst_level_q",  int'(level_q), 0);
      chk("rst_pulses",   int'({changed, up, down}), 0);
      chk("rst_result",   int'(result), 7'b0011111);
    end

    // Release with a=5: up pulse on edge 1, quiet on edge 2.
    @(negedge clk);
    rst_n = 1'b1;
    model_level = 0;
    push_edge(5);
    drive(5);

    // 5 -> 2 -> 2 -> 7.
    drive(2);
    drive(2);
    drive(7);

    // Asynchronous reset while the up pulse is high.
    @(negedge clk);
    #1;
    chk("pre_rst_up", int'(up), 1);
    rst_n = 1'b0;
    #1;
    chk("async_up",       int'(up), 0);
    chk("async_changed",  int'(changed), 0);
    chk("async_level_q",  int'(level_q), 0);
    chk("async_result_q", int'(result_q), 0);
    chk("async_result",   int'(result), 7'b1111111);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_level = 0;
    push_edge(7);

    // Random levels.
    for (int n = 0; n < 1000; n++) begin
      drive(int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #3;
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
